// File: rtl/rr_arb_2.sv
// Two-input arbiter with grant-on-accept pointer update; RAM_ARB_FIXED_PRIO_EN
// turns it into a fixed-priority arbiter where A always wins.
module rr_arb_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign gnt_a = req_a;
  assign gnt_b = req_b & ~req_a;
`else
  // fav_b: requester B wins the next contention (A was granted last)
  logic fav_b;

  assign gnt_a = req_a & (~req_b | ~fav_b);
  assign gnt_b = req_b & (~req_a | fav_b);

  // A grant is always an accepted transfer, so the pointer moves on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     fav_b <= 1'b0;
    else if (gnt_a) fav_b <= 1'b1;
    else if (gnt_b) fav_b <= 1'b0;
  end
`endif

endmodule

// File: rtl/ram_2port_arbiter.sv
// Shares a dual-port RAM between requesters A and B with independent write and read
// arbitration; RAM_ARB_FIXED_PRIO_EN selects fixed priority (A wins) instead of round-robin.
module ram_2port_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_A_Req,
  input  logic                     i_A_Wr,
  input  logic [$clog2(DEPTH)-1:0] i_A_Addr,
  input  logic [WIDTH-1:0]         i_A_Data,
  output logic                     o_A_Ack,
  output logic                     o_A_Rd_DV,
  output logic [WIDTH-1:0]         o_A_Rd_Data,
  input  logic                     i_B_Req,
  input  logic                     i_B_Wr,
  input  logic [$clog2(DEPTH)-1:0] i_B_Addr,
  input  logic [WIDTH-1:0]         i_B_Data,
  output logic                     o_B_Ack,
  output logic                     o_B_Rd_DV,
  output logic [WIDTH-1:0]         o_B_Rd_Data,
  output logic [$clog2(DEPTH)-1:0] o_Wr_Addr,
  output logic                     o_Wr_DV,
  output logic [WIDTH-1:0]         o_Wr_Data,
  output logic [$clog2(DEPTH)-1:0] o_Rd_Addr,
  output logic                     o_Rd_En,
  input  logic                     i_Rd_DV,
  input  logic [WIDTH-1:0]         i_Rd_Data
);

  localparam int   AW    = $clog2(DEPTH);
  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;

  logic wr_gnt_a, wr_gnt_b, rd_gnt_a, rd_gnt_b;
  logic tag_vld_p1, tag_id_p1, tag_vld_p2, tag_id_p2;

  rr_arb_2 u_wr_arb (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .req_a (i_A_Req & i_A_Wr),
    .req_b (i_B_Req & i_B_Wr),
    .gnt_a (wr_gnt_a),
    .gnt_b (wr_gnt_b)
  );

  rr_arb_2 u_rd_arb (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .req_a (i_A_Req & ~i_A_Wr),
    .req_b (i_B_Req & ~i_B_Wr),
    .gnt_a (rd_gnt_a),
    .gnt_b (rd_gnt_b)
  );

  // Each requester targets only one port per cycle, so its ack is that port's grant
  assign o_A_Ack = wr_gnt_a | rd_gnt_a;
  assign o_B_Ack = wr_gnt_b | rd_gnt_b;

  // Stage p1: registered RAM commands and read tag, captured on the accept edge
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Wr_DV    <= 1'b0;
      o_Wr_Addr  <= '0;
      o_Wr_Data  <= '0;
      o_Rd_En    <= 1'b0;
      o_Rd_Addr  <= '0;
      tag_vld_p1 <= 1'b0;
      tag_id_p1  <= TAG_A;
    end else begin
      o_Wr_DV <= wr_gnt_a | wr_gnt_b;
      if (wr_gnt_a) begin
        o_Wr_Addr <= i_A_Addr;
        o_Wr_Data <= i_A_Data;
      end else if (wr_gnt_b) begin
        o_Wr_Addr <= i_B_Addr;
        o_Wr_Data <= i_B_Data;
      end
      o_Rd_En <= rd_gnt_a | rd_gnt_b;
      if (rd_gnt_a)      o_Rd_Addr <= i_A_Addr;
      else if (rd_gnt_b) o_Rd_Addr <= i_B_Addr;
      tag_vld_p1 <= rd_gnt_a | rd_gnt_b;
      tag_id_p1  <= rd_gnt_b ? TAG_B : TAG_A;
    end
  end

  // Stage p2: tag aligned with the RAM's registered read data
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tag_vld_p2 <= 1'b0;
      tag_id_p2  <= TAG_A;
    end else begin
      tag_vld_p2 <= tag_vld_p1;
      tag_id_p2  <= tag_id_p1;
    end
  end

  assign o_A_Rd_DV   = i_Rd_DV & tag_vld_p2 & (tag_id_p2 == TAG_A);
  assign o_B_Rd_DV   = i_Rd_DV & tag_vld_p2 & (tag_id_p2 == TAG_B);
  assign o_A_Rd_Data = i_Rd_Data;
  assign o_B_Rd_Data = i_Rd_Data;

endmodule

// File: tb/tb_ram_2port_arbiter.sv
// Self-checking bench for ram_2port_arbiter: directed scenarios plus randomized traffic
// against a behavioural model; RAM_ARB_FIXED_PRIO_EN adds the fixed-priority scenario.
module tb_ram_2port_arbiter;
  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [WIDTH-1:0] a_data = '0, b_data = '0;
  logic a_ack, a_rd_dv, b_ack, b_rd_dv;
  logic [WIDTH-1:0] a_rd_data, b_rd_data;
  logic [AW-1:0] wr_addr, rd_addr;
  logic wr_dv, rd_en;
  logic [WIDTH-1:0] wr_data;
  logic ram_rd_dv;
  logic [WIDTH-1:0] ram_rd_data;
  logic [WIDTH-1:0] ram [DEPTH];

  always #5 clk = ~clk;

  ram_2port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_A_Req(a_req), .i_A_Wr(a_wr), .i_A_Addr(a_addr), .i_A_Data(a_data),
    .o_A_Ack(a_ack), .o_A_Rd_DV(a_rd_dv), .o_A_Rd_Data(a_rd_data),
    .i_B_Req(b_req), .i_B_Wr(b_wr), .i_B_Addr(b_addr), .i_B_Data(b_data),
    .o_B_Ack(b_ack), .o_B_Rd_DV(b_rd_dv), .o_B_Rd_Data(b_rd_data),
    .o_Wr_Addr(wr_addr), .o_Wr_DV(wr_dv), .o_Wr_Data(wr_data),
    .o_Rd_Addr(rd_addr), .o_Rd_En(rd_en),
    .i_Rd_DV(ram_rd_dv), .i_Rd_Data(ram_rd_data)
  );

  // Dual-port RAM: registered read, read valid echoes read enable
  always @(posedge clk) begin
    if (wr_dv) ram[wr_addr] <= wr_data;
    ram_rd_dv <= rd_en;
    if (rd_en) ram_rd_data <= ram[rd_addr];
  end

  // Behavioural model
  typedef struct { int due; bit id; logic [WIDTH-1:0] data; } rd_t;
  rd_t q[$];
  logic [WIDTH-1:0] mem_m [DEPTH];
  bit fav_wr_b, fav_rd_b;
  int cyc;
  bit e_gwa, e_gwb, e_gra, e_grb, e_ack_a, e_ack_b, e_dv_a, e_dv_b, e_wr_dv, e_rd_en;
  logic [WIDTH-1:0] e_rdata, e_wr_data;
  logic [AW-1:0] e_wr_addr, e_rd_addr;
  int pass_cnt = 0, total = 0;

  function automatic bit pick_b(bit want_a, bit want_b, bit fav_b);
`ifdef RAM_ARB_FIXED_PRIO_EN
    return want_b && !want_a;
`else
    return want_b && (!want_a || fav_b);
`endif
  endfunction

  task automatic clear_model();
    q.delete();
    fav_wr_b = 0; fav_rd_b = 0; cyc = 0;
    e_wr_dv = 0; e_rd_en = 0; e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0;
  endtask

  // Predict combinational outputs for the current cycle
  task automatic eval();
    @(negedge clk);
    e_gwb = pick_b(a_req && a_wr, b_req && b_wr, fav_wr_b);
    e_gwa = a_req && a_wr && !e_gwb;
    e_grb = pick_b(a_req && !a_wr, b_req && !b_wr, fav_rd_b);
    e_gra = a_req && !a_wr && !e_grb;
    e_ack_a = e_gwa || e_gra;
    e_ack_b = e_gwb || e_grb;
    e_dv_a = 0; e_dv_b = 0; e_rdata = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_dv_a = !q[0].id; e_dv_b = q[0].id; e_rdata = q[0].data;
    end
  endtask

  // Advance the model over the accept edge; reads see memory before same-edge writes
  task automatic commit();
    logic [AW-1:0] ad;
    @(posedge clk);
    if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    cyc++;
    e_rd_en = e_gra || e_grb;
    if (e_rd_en) begin
      ad = e_gra ? a_addr : b_addr;
      q.push_back('{due: cyc + 1, id: e_grb, data: mem_m[ad]});
      e_rd_addr = ad;
      fav_rd_b = e_gra;
    end
    e_wr_dv = e_gwa || e_gwb;
    if (e_wr_dv) begin
      e_wr_addr = e_gwa ? a_addr : b_addr;
      e_wr_data = e_gwa ? a_data : b_data;
      mem_m[e_wr_addr] = e_wr_data;
      fav_wr_b = e_gwa;
    end
    #1;
  endtask

  task automatic do_reset();
    a_req = 0; b_req = 0;
    @(negedge clk); rst_n = 0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    a_req = 0; b_req = 0; rst_n = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    total++; if (wr_dv !== 1'b0) $display("FAIL reset_wr_dv: got %b want 0", wr_dv); else pass_cnt++;
    total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else pass_cnt++;
    total++; if (wr_addr !== '0 || rd_addr !== '0) $display("FAIL reset_addr: got %h/%h want 0/0", wr_addr, rd_addr); else pass_cnt++;
    total++; if (wr_data !== '0) $display("FAIL reset_wr_data: got %h want 0", wr_data); else pass_cnt++;
    total++; if (a_rd_dv !== 1'b0 || b_rd_dv !== 1'b0) $display("FAIL reset_rd_dv: got %b%b want 00", a_rd_dv, b_rd_dv); else pass_cnt++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    a_req = 1; a_wr = 1; a_addr = 8'd5; a_data = 16'h1234; b_req = 0;
    eval();
    total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) $display("FAIL single_ack: got %b%b want 10", a_ack, b_ack); else pass_cnt++;
    commit();
    a_req = 0;
    total++; if (wr_dv !== 1'b1 || wr_addr !== 8'd5 || wr_data !== 16'h1234 || rd_en !== 1'b0)
      $display("FAIL single_cmd: got dv=%b addr=%h data=%h rd_en=%b want 1/05/1234/0", wr_dv, wr_addr, wr_data, rd_en); else pass_cnt++;
    eval(); commit();
    total++; if (wr_dv !== 1'b0 || wr_addr !== 8'd5 || wr_data !== 16'h1234)
      $display("FAIL single_idle_hold: got dv=%b addr=%h data=%h want 0/05/1234", wr_dv, wr_addr, wr_data); else pass_cnt++;
  endtask

  task automatic test_alternate_write();
    bit want_a;
    do_reset();
    a_req = 1; a_wr = 1; a_addr = 8'd1; b_req = 1; b_wr = 1; b_addr = 8'd2;
    for (int k = 0; k < 4; k++) begin
      a_data = 16'($urandom); b_data = 16'($urandom);
`ifdef RAM_ARB_FIXED_PRIO_EN
      want_a = 1;
`else
      want_a = (k % 2) == 0;
`endif
      eval();
      total++; if (a_ack !== want_a || b_ack !== !want_a) $display("FAIL alt_ack[%0d]: got %b%b want %b%b", k, a_ack, b_ack, want_a, !want_a); else pass_cnt++;
      commit();
      total++; if (wr_dv !== 1'b1 || wr_addr !== (want_a ? 8'd1 : 8'd2) || wr_data !== (want_a ? a_data : b_data))
        $display("FAIL alt_cmd[%0d]: got dv=%b addr=%h data=%h", k, wr_dv, wr_addr, wr_data); else pass_cnt++;
    end
    a_req = 0; b_req = 0;
  endtask

  task automatic test_same_addr();
    a_req = 1; a_wr = 1; a_addr = 8'd7; a_data = 16'hAAAA; b_req = 0;
    eval(); commit();
    a_data = 16'hBBBB; b_req = 1; b_wr = 0; b_addr = 8'd7;
    eval();
    total++; if (a_ack !== 1'b1 || b_ack !== 1'b1) $display("FAIL same_ack: got %b%b want 11", a_ack, b_ack); else pass_cnt++;
    commit();
    a_req = 0; b_req = 0;
    eval(); commit();
    eval();
    total++; if (b_rd_dv !== 1'b1 || a_rd_dv !== 1'b0 || b_rd_data !== 16'hAAAA)
      $display("FAIL same_old_data: got dv=%b%b data=%h want dv=01 data=aaaa", a_rd_dv, b_rd_dv, b_rd_data); else pass_cnt++;
    commit();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] pre [3];
    bit tdv_a [6], tdv_b [6];
    logic [WIDTH-1:0] tdat [6];
    pre[0] = 16'h0033; pre[1] = 16'h0044; pre[2] = 16'h0055;
    tdv_a = '{0, 0, 1, 0, 1, 0};
    tdv_b = '{0, 0, 0, 1, 0, 0};
    tdat  = '{16'h0, 16'h0, 16'h0033, 16'h0044, 16'h0055, 16'h0};
    b_req = 0; a_req = 1; a_wr = 1;
    for (int k = 0; k < 3; k++) begin
      a_addr = AW'(3 + k); a_data = pre[k];
      eval();
      total++; if (a_ack !== 1'b1) $display("FAIL b2b_wr_ack[%0d]: got %b want 1", k, a_ack); else pass_cnt++;
      commit();
    end
    a_req = 0;
    for (int k = 0; k < 6; k++) begin
      a_req = (k == 0 || k == 2); a_wr = 0; a_addr = AW'(3 + k);
      b_req = (k == 1); b_wr = 0; b_addr = 8'd4;
      eval();
      total++; if (a_rd_dv !== tdv_a[k] || b_rd_dv !== tdv_b[k]) $display("FAIL b2b_rd_dv[%0d]: got %b%b want %b%b", k, a_rd_dv, b_rd_dv, tdv_a[k], tdv_b[k]); else pass_cnt++;
      if (tdv_a[k] || tdv_b[k]) begin
        total++; if ((tdv_a[k] ? a_rd_data : b_rd_data) !== tdat[k]) $display("FAIL b2b_rd_data[%0d]: got %h/%h want %h", k, a_rd_data, b_rd_data, tdat[k]); else pass_cnt++;
      end
      commit();
    end
    a_req = 0; b_req = 0;
  endtask

  task automatic test_random();
    a_req = 1; a_wr = 1; b_req = 0;
    for (int k = 0; k < 8; k++) begin
      a_addr = AW'(k); a_data = 16'($urandom);
      eval(); commit();
    end
    a_req = 0;
    e_ack_a = 0; e_ack_b = 0;
    for (int k = 0; k < 300; k++) begin
      if (!(a_req && !e_ack_a)) begin
        a_req = $urandom_range(0, 3) != 0; a_wr = $urandom_range(0, 1);
        a_addr = AW'($urandom_range(0, 7)); a_data = 16'($urandom);
      end
      if (!(b_req && !e_ack_b)) begin
        b_req = $urandom_range(0, 3) != 0; b_wr = $urandom_range(0, 1);
        b_addr = AW'($urandom_range(0, 7)); b_data = 16'($urandom);
      end
      eval();
      total++; if (a_ack !== e_ack_a || b_ack !== e_ack_b) $display("FAIL rnd_ack[%0d]: got %b%b want %b%b", k, a_ack, b_ack, e_ack_a, e_ack_b); else pass_cnt++;
      total++; if (a_rd_dv !== e_dv_a || b_rd_dv !== e_dv_b) $display("FAIL rnd_rd_dv[%0d]: got %b%b want %b%b", k, a_rd_dv, b_rd_dv, e_dv_a, e_dv_b); else pass_cnt++;
      if (e_dv_a || e_dv_b) begin
        total++; if ((e_dv_a ? a_rd_data : b_rd_data) !== e_rdata) $display("FAIL rnd_rd_data[%0d]: got %h/%h want %h", k, a_rd_data, b_rd_data, e_rdata); else pass_cnt++;
      end
      commit();
      total++; if (wr_dv !== e_wr_dv || wr_addr !== e_wr_addr || wr_data !== e_wr_data)
        $display("FAIL rnd_wr_cmd[%0d]: got %b/%h/%h want %b/%h/%h", k, wr_dv, wr_addr, wr_data, e_wr_dv, e_wr_addr, e_wr_data); else pass_cnt++;
      total++; if (rd_en !== e_rd_en || rd_addr !== e_rd_addr)
        $display("FAIL rnd_rd_cmd[%0d]: got %b/%h want %b/%h", k, rd_en, rd_addr, e_rd_en, e_rd_addr); else pass_cnt++;
    end
    a_req = 0; b_req = 0;
    repeat (3) begin eval(); commit(); end
  endtask

  task automatic test_reset_mid();
    a_req = 1; a_wr = 0; a_addr = 8'd3; b_req = 0;
    eval(); commit();
    a_req = 0;
    rst_n = 0;
    clear_model();
    #1;
    total++; if (rd_en !== 1'b0 || wr_dv !== 1'b0 || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0)
      $display("FAIL mid_reset_outputs: got rd_en=%b wr_dv=%b addr=%h/%h data=%h want all 0", rd_en, wr_dv, rd_addr, wr_addr, wr_data); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      eval();
      total++; if (a_rd_dv !== 1'b0 || b_rd_dv !== 1'b0) $display("FAIL mid_reset_rd_dv[%0d]: got %b%b want 00", k, a_rd_dv, b_rd_dv); else pass_cnt++;
      commit();
    end
    a_req = 1; a_wr = 1; a_addr = 8'd9; b_req = 1; b_wr = 1; b_addr = 8'd10;
    eval();
    total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) $display("FAIL mid_reset_favour_a: got %b%b want 10", a_ack, b_ack); else pass_cnt++;
    commit();
    a_req = 0; b_req = 0;
  endtask

`ifdef RAM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    a_req = 1; a_wr = 0; b_req = 1; b_wr = 0;
    for (int k = 0; k < 5; k++) begin
      a_addr = AW'($urandom_range(0, 7)); b_addr = AW'($urandom_range(0, 7));
      eval();
      total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) $display("FAIL fixed_prio_ack[%0d]: got %b%b want 10", k, a_ack, b_ack); else pass_cnt++;
      commit();
    end
    a_req = 0; b_req = 0;
    repeat (3) begin eval(); commit(); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_write();
    test_alternate_write();
    test_same_addr();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef RAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ram_2port_arbiter.md
Name: ram_2port_arbiter

Overview:
- Shares one dual-port RAM (separate write port and read port, 1-cycle registered read, o_Rd_DV echoes read enable) between two requesters, A and B.
- Arbitrates the write port and the read port independently, each round-robin, so A can write while B reads in the same cycle.
- Registers all RAM command outputs and routes returning read data to the requester that issued the read.
- Sits between client logic and the RAM instance; single clock domain.

Parameters:
- WIDTH, 16, data width; must match the RAM.
- DEPTH, 256, RAM depth; address width AW = $clog2(DEPTH).

Ports:
- i_Clk  in  1  clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_A_Req  in  1  requester A command valid
- i_A_Wr  in  1  1 = write, 0 = read
- i_A_Addr  in  AW  A address
- i_A_Data  in  WIDTH  A write data
- o_A_Ack  out  1  A command accepted this cycle (combinational)
- o_A_Rd_DV  out  1  A read data valid
- o_A_Rd_Data  out  WIDTH  A read data
- i_B_Req, i_B_Wr, i_B_Addr, i_B_Data, o_B_Ack, o_B_Rd_DV, o_B_Rd_Data: same as A, for requester B
- o_Wr_Addr  out  AW  RAM write address
- o_Wr_DV  out  1  RAM write enable
- o_Wr_Data  out  WIDTH  RAM write data
- o_Rd_Addr  out  AW  RAM read address
- o_Rd_En  out  1  RAM read enable
- i_Rd_DV  in  1  RAM read valid
- i_Rd_Data  in  WIDTH  RAM read data

Behaviour:
- Clock and reset: one clock, i_Clk; reset i_Rst_L is asynchronous, active-low.
- Reset values: o_Wr_DV, o_Rd_En, o_Wr_Addr, o_Wr_Data, o_Rd_Addr = 0; read-tag pipeline cleared; both round-robin pointers favour A.
- Handshake: a command transfers on any rising edge where Req=1 and Ack=1.
  - Requester holds Addr, Data and Wr stable while Req=1 and Ack=0.
  - Ack depends only on the current Req/Wr inputs and the pointer state; it never depends on RAM inputs.
- Per-port arbitration (write port shown; the read port is identical using Wr=0):
  - Only A wants the port: grant A.
  - Only B wants the port: grant B.
  - Both want the port: grant the requester not granted last on that port.
  - Pointer updates only on an accepted transfer.
  - Each requester issues at most one command per cycle, so each Ack is simply that requester's grant on the port its Wr selects.
- Command output (registered): on the accept edge, o_Wr_DV/o_Rd_En <= 1 with the winner's Addr/Data; otherwise DV/En <= 0. Addr/Data hold their last value when idle.
- Read tag:
  - Stage 1 is registered at the accept edge; stage 2 is registered one edge later, alongside the RAM's o_Rd_DV.
  - o_X_Rd_DV = i_Rd_DV & (tag2 == X).
  - o_X_Rd_Data = i_Rd_Data, unconditionally.
  - Latency: data valid in the 2nd cycle after the accept edge; fully pipelined, one read per cycle.
- Same address: when a write and a read to the same address are accepted on the same edge, the read returns the old data (both hit the RAM on the same edge).
- Back-to-back: the same requester may be granted every cycle if the other is idle.
- Reset mid-operation: in-flight read tags are discarded. Any i_Rd_DV after reset release with a cleared tag (DV bit 0) produces no o_X_Rd_DV.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: A always wins contention on both ports; pointers removed; B may starve.
- Undefined: round-robin as above.

Decomposition:
- No shared package needed.
- Localparams AW and tag encoding (TAG_A=0, TAG_B=1) live in the module.
- One natural sub-module: rr_arb_2, a 2-input round-robin arbiter with pointer register and grant-on-accept update. It is instantiated twice, once for write grant and once for read grant; under the macro it reduces to fixed priority.

Test Plan:
- Reset, then A writes 0x1234 to addr 5 -> o_A_Ack=1 same cycle; next cycle o_Wr_DV=1, o_Wr_Addr=5, o_Wr_Data=0x1234.
- A and B both write continuously (A addr 1, B addr 2) for 4 cycles -> grants alternate A,B,A,B; each Ack high every other cycle.
- A write to 7 and B read of 7 in the same cycle -> both Acked; B gets old value of addr 7 two cycles later with o_B_Rd_DV=1, o_A_Rd_DV=0.
- Back-to-back reads A@3, B@4, A@5 (contents 0x33, 0x44, 0x55) -> o_A_Rd_DV/o_B_Rd_DV pulse in order with 0x33, 0x44, 0x55; no cross-routing.
- Assert i_Rst_L low one cycle after accepting A's read -> no o_A_Rd_DV afterward; outputs 0; pointer favours A.
- With RAM_ARB_FIXED_PRIO_EN, both read continuously for 5 cycles -> A Acked every cycle, o_B_Ack=0 throughout.
